// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Gray/binary conversion helpers shared by FIFO pointer logic
//                and its checkers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Async-FIFO pointer: binary RAM address plus registered
//                Gray pointer for crossing into the other clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            status,
    output logic [size-1:0] adr_output,
    output logic [size:0]   ptr_output
);

    logic            inc_en;
    logic [size:0]   bin_q;
    logic [size:0]   bin_d;
    logic [size:0]   gray_q;
    logic [size:0]   gray_d;

    always_comb begin
        inc_en = inc & ~status;
        bin_d  = bin_q + {{size{1'b0}}, inc_en};
        gray_d = (bin_d >> 1) ^ bin_d;
    end

    // Gray is registered from bin_d rather than decoded from bin_q so the
    // pointer leaving this domain comes straight from flops.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign adr_output = bin_q[size-1:0];
    assign ptr_output = gray_q;

`ifndef SYNTHESIS
    logic            chk_seen_q;
    logic            chk_live_q;
    logic            chk_en_q;
    logic [size:0]   chk_ptr_q;

    always_ff @(posedge clk) begin
        chk_seen_q <= chk_seen_q | rst_n;
        chk_live_q <= chk_seen_q & ~rst_n;
        chk_en_q   <= inc_en;
        chk_ptr_q  <= gray_q;
        if (chk_live_q) begin
            if (chk_en_q) begin
                assert ($countones(gray_q ^ chk_ptr_q) == 1)
                    else $error("gray_counter: pointer step changed other than one bit");
            end else begin
                assert (gray_q == chk_ptr_q)
                    else $error("gray_counter: pointer moved while disabled");
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Directed self-checking bench for gray_counter at size=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;
    import fifo_pkg::*;

    localparam int SIZE = 4;

    logic            clk;
    logic            rst_n;
    logic            inc;
    logic            status;
    logic [SIZE-1:0] adr_output;
    logic [SIZE:0]   ptr_output;

    int n_checks = 0;
    int n_fail   = 0;

    gray_counter #(.size(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (inc),
        .status     (status),
        .adr_output (adr_output),
        .ptr_output (ptr_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle away from it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; inc = 1'b1; status = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (adr_output !== 4'd0) begin
                n_fail++; $display("FAIL reset_adr cyc%0d got %0d want 0", i, adr_output);
            end
            n_checks++;
            if (ptr_output !== 5'b00000) begin
                n_fail++; $display("FAIL reset_ptr cyc%0d got %b want 00000", i, ptr_output);
            end
        end
    endtask

    task automatic test_count();
        logic [3:0] exp_adr [3] = '{4'd1, 4'd2, 4'd3};
        logic [4:0] exp_ptr [3] = '{5'b00001, 5'b00011, 5'b00010};
        rst_n = 1'b0; inc = 1'b1; status = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (adr_output !== exp_adr[i] || ptr_output !== exp_ptr[i]) begin
                n_fail++;
                $display("FAIL count_step%0d got adr=%0d ptr=%b want adr=%0d ptr=%b",
                         i, adr_output, ptr_output, exp_adr[i], exp_ptr[i]);
            end
        end
    endtask

    task automatic test_block();
        step(); step();
        n_checks++;
        if (adr_output !== 4'd5 || ptr_output !== 5'b00111) begin
            n_fail++; $display("FAIL block_setup got adr=%0d ptr=%b want adr=5 ptr=00111", adr_output, ptr_output);
        end
        status = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (adr_output !== 4'd5 || ptr_output !== 5'b00111) begin
                n_fail++; $display("FAIL block_hold%0d got adr=%0d ptr=%b want adr=5 ptr=00111", i, adr_output, ptr_output);
            end
        end
        status = 1'b0;
        step();
        n_checks++;
        if (adr_output !== 4'd6 || ptr_output !== 5'b00101) begin
            n_fail++; $display("FAIL block_release got adr=%0d ptr=%b want adr=6 ptr=00101", adr_output, ptr_output);
        end
        inc = 1'b0;
        step(); step();
        n_checks++;
        if (adr_output !== 4'd6 || ptr_output !== 5'b00101) begin
            n_fail++; $display("FAIL idle_hold got adr=%0d ptr=%b want adr=6 ptr=00101", adr_output, ptr_output);
        end
    endtask

    task automatic test_addr_wrap();
        rst_n = 1'b1; inc = 1'b0; status = 1'b0;
        step();
        rst_n = 1'b0; inc = 1'b1;
        for (int i = 0; i < 16; i++) step();
        n_checks++;
        if (adr_output !== 4'd0 || ptr_output !== 5'b11000) begin
            n_fail++; $display("FAIL addr_wrap got adr=%0d ptr=%b want adr=0 ptr=11000", adr_output, ptr_output);
        end
        // Full pattern against a read pointer of 00000: top two bits inverted, rest equal.
        n_checks++;
        if (ptr_output !== {~2'b00, 3'b000}) begin
            n_fail++; $display("FAIL full_detect got ptr=%b want 11000", ptr_output);
        end
    endtask

    task automatic test_ptr_wrap();
        logic [31:0] prev_b;
        logic [31:0] cur_b;
        logic [4:0]  prev_p;
        int          bad;
        bad = 0;
        prev_p = ptr_output;
        prev_b = gray2bin({27'd0, ptr_output});
        for (int i = 0; i < 16; i++) begin
            step();
            cur_b = gray2bin({27'd0, ptr_output});
            if (cur_b !== ((prev_b + 32'd1) & 32'h1F) || $countones(ptr_output ^ prev_p) != 1) bad++;
            if (i == 14) begin
                n_checks++;
                if (ptr_output !== 5'b10000 || adr_output !== 4'd15) begin
                    n_fail++; $display("FAIL ptr_top got adr=%0d ptr=%b want adr=15 ptr=10000", adr_output, ptr_output);
                end
            end
            prev_b = cur_b;
            prev_p = ptr_output;
        end
        n_checks++;
        if (ptr_output !== 5'b00000 || adr_output !== 4'd0) begin
            n_fail++; $display("FAIL ptr_wrap got adr=%0d ptr=%b want adr=0 ptr=00000", adr_output, ptr_output);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL gray_monotonic got %0d bad steps want 0", bad);
        end
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if (adr_output !== 4'd9 || ptr_output !== 5'b01101) begin
            n_fail++; $display("FAIL midrun_setup got adr=%0d ptr=%b want adr=9 ptr=01101", adr_output, ptr_output);
        end
        rst_n = 1'b1; inc = 1'b1;
        step();
        n_checks++;
        if (adr_output !== 4'd0 || ptr_output !== 5'b00000) begin
            n_fail++; $display("FAIL midrun_reset got adr=%0d ptr=%b want adr=0 ptr=00000", adr_output, ptr_output);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (adr_output !== 4'd1 || ptr_output !== 5'b00001) begin
            n_fail++; $display("FAIL midrun_resume got adr=%0d ptr=%b want adr=1 ptr=00001", adr_output, ptr_output);
        end
    endtask

    initial begin
        rst_n = 1'b1; inc = 1'b1; status = 1'b0;
        #2;
        test_reset();
        test_count();
        test_block();
        test_addr_wrap();
        test_ptr_wrap();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
